// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory and releases the CPU when done.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   load_start/load_len request a load of load_len words (1..MEM_WORDS)
//   byte_valid/byte_data/byte_ready  program byte stream, MSB of word first
//   mem_we/mem_waddr/mem_wdata       instruction-memory write port
//   cpu_run             high while the loaded program may execute
//   load_done           one-cycle pulse on entry to RUN
//   load_err            sticky flag for an out-of-range load_len
module imem_loader_ctrl #(
    parameter int          MEM_WORDS = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  load_len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_e;

    localparam logic [31:0] MAX_LEN = 32'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        start_ok;
    logic        last_word;

    assign start_ok  = (load_len != 8'd0) &&
                       ({24'd0, load_len} <= MAX_LEN);
    assign last_word = (word_idx_q == len_q - 8'd1);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        done_d     = 1'b0;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = 32'd0;
        cpu_run    = 1'b0;

        unique case (state_q)
            IDLE, RUN: begin
                cpu_run = (state_q == RUN);
                if (load_start && start_ok) begin
                    state_d    = LOAD;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 8'd0;
                    len_d      = load_len;
                    err_d      = 1'b0;
                end else if (load_start) begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    // shifting left leaves the first byte in [31:24]
                    wdata_d    = {wdata_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                mem_waddr  = BASE_ADDR + {22'd0, word_idx_q, 2'b00};
                word_idx_d = word_idx_q + 8'd1;
                if (last_word) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 8'd0;
            len_q      <= 8'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign mem_wdata = wdata_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: table-driven and randomized checks of the loader
// against a word-list model built from the byte stream.
module tb_imem_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  src[$];
    int          wr_cyc, done_cyc, acc_cyc, done_cnt;
    logic        done_run, run_at_we;

    typedef struct {
        int len;
        int gap;
        bit exp_err;
        bit from_run;
    } vec_t;

    vec_t tbl[9];

    imem_loader_ctrl dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture writes, done pulses and byte acceptances.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
            wr_cyc    = cyc;
            run_at_we = cpu_run;
            checks++;
            if (mem_waddr[1:0] != 2'b00 || mem_waddr > 32'h1FC) begin
                errors++;
                $display("FAIL waddr_range: got %h max 000001fc", mem_waddr);
            end
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_run = cpu_run;
        end
        if (byte_valid && byte_ready) acc_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill_src(input int n, input bit incr);
        src.delete();
        for (int k = 0; k < n; k++)
            src.push_back(incr ? 8'(k) : 8'($urandom));
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            step();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got ready=0 expected ready=1");
        end
        step();
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // Expected memory image: word i at 4*i, bytes src[4i..4i+3] MSB first.
    task automatic check_writes(input int n);
        logic [31:0] ew;
        chk32("write_count", 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            ew = {src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]};
            chk32($sformatf("waddr[%0d]", i), wr_addr[i], 32'(4 * i));
            chk32($sformatf("wdata[%0d]", i), wr_data[i], ew);
        end
    endtask

    task automatic do_load(input int len, input int gap,
                           input int pulse_at, input logic [7:0] pulse_len);
        int start;
        clear_mon();
        load_start = 1'b1;
        load_len   = 8'(len);
        step();
        load_start = 1'b0;
        load_len   = 8'($urandom);
        start      = cyc - 1;
        chk1("entry_cpu_run", cpu_run, 1'b0);
        chk1("entry_byte_ready", byte_ready, 1'b1);
        chk1("entry_load_err", load_err, 1'b0);
        for (int k = 0; k < 4 * len; k++) begin
            if (k == pulse_at) begin
                load_start = 1'b1;
                load_len   = pulse_len;
            end
            send_byte(src[k]);
            load_start = 1'b0;
            if (k < 4 * len - 1) repeat (gap) step();
        end
        repeat (2) step();
        chk32("done_count", 32'(done_cnt), 32'd1);
        chk32("we_latency", 32'(wr_cyc - acc_cyc), 32'd1);
        chk32("done_latency", 32'(done_cyc - acc_cyc), 32'd2);
        if (gap == 0)
            chk32("done_total", 32'(done_cyc - start), 32'(1 + 5 * len));
        chk1("run_with_done", done_run, 1'b1);
        chk1("run_at_last_we", run_at_we, 1'b0);
        chk1("run_after", cpu_run, 1'b1);
        chk1("done_after", load_done, 1'b0);
        chk1("ready_in_run", byte_ready, 1'b0);
        chk1("err_after", load_err, 1'b0);
        check_writes(len);
    endtask

    task automatic try_bad(input int len, input logic in_run);
        clear_mon();
        load_start = 1'b1;
        load_len   = 8'(len);
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        step();
        load_start = 1'b0;
        chk1("bad_err", load_err, 1'b1);
        chk1("bad_ready", byte_ready, 1'b0);
        chk1("bad_cpu_run", cpu_run, in_run);
        repeat (4) begin
            byte_data = 8'($urandom);
            step();
        end
        byte_valid = 1'b0;
        chk32("bad_no_we", 32'(wr_addr.size()), 32'd0);
        chk1("bad_err_sticky", load_err, 1'b1);
    endtask

    initial begin
        logic [7:0] prog[8];
        int len, gap, pa;
        logic [31:0] w0;

        tbl[0] = '{0,   0, 1'b1, 1'b0};
        tbl[1] = '{129, 0, 1'b1, 1'b0};
        tbl[2] = '{255, 0, 1'b1, 1'b0};
        tbl[3] = '{0,   0, 1'b1, 1'b1};
        tbl[4] = '{200, 0, 1'b1, 1'b1};
        tbl[5] = '{1,   0, 1'b0, 1'b0};
        tbl[6] = '{3,   1, 1'b0, 1'b0};
        tbl[7] = '{128, 0, 1'b0, 1'b0};
        tbl[8] = '{4,   2, 1'b0, 1'b1};
        prog = '{8'h00, 8'h22, 8'h18, 8'h20, 8'hAC, 8'h01, 8'h00, 8'h00};

        rst        = 1'b1;
        load_start = 1'b0;
        load_len   = 8'd0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        done_cnt   = 0;
        repeat (2) step();
        chk1("rst_cpu_run", cpu_run, 1'b0);
        chk1("rst_byte_ready", byte_ready, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_load_done", load_done, 1'b0);
        chk1("rst_load_err", load_err, 1'b0);
        chk32("rst_waddr", mem_waddr, 32'd0);
        chk32("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        byte_valid = 1'b0;

        // Reference program, back to back and then with 3-cycle gaps.
        src.delete();
        for (int k = 0; k < 8; k++) src.push_back(prog[k]);
        do_load(2, 0, -1, 8'd0);
        chk32("prog_w0", wr_data[0], 32'h00221820);
        chk32("prog_w1", wr_data[1], 32'hAC010000);
        do_load(2, 3, -1, 8'd0);
        chk32("gap_done_late", 32'(done_cyc - acc_cyc), 32'd2);

        for (int t = 0; t < 9; t++) begin
            do_reset();
            if (tbl[t].from_run) begin
                fill_src(4, 1'b0);
                do_load(1, 0, -1, 8'd0);
            end
            if (tbl[t].exp_err) begin
                try_bad(tbl[t].len, tbl[t].from_run);
            end else begin
                fill_src(4 * tbl[t].len, 1'b0);
                do_load(tbl[t].len, tbl[t].gap, -1, 8'd0);
            end
        end

        // Full memory with incrementing bytes.
        do_reset();
        fill_src(512, 1'b1);
        do_load(128, 0, -1, 8'd0);
        chk32("full_last_addr", wr_addr[wr_addr.size() - 1], 32'h1FC);
        chk32("full_last_data", wr_data[wr_data.size() - 1], 32'hFCFDFEFF);

        // Reset after six bytes of a four-word load.
        do_reset();
        fill_src(16, 1'b0);
        w0 = {src[0], src[1], src[2], src[3]};
        clear_mon();
        load_start = 1'b1;
        load_len   = 8'd4;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 6; k++) send_byte(src[k]);
        rst = 1'b1;
        step();
        chk1("mid_rst_cpu_run", cpu_run, 1'b0);
        chk1("mid_rst_ready", byte_ready, 1'b0);
        chk1("mid_rst_we", mem_we, 1'b0);
        chk1("mid_rst_done", load_done, 1'b0);
        chk1("mid_rst_err", load_err, 1'b0);
        chk32("mid_rst_waddr", mem_waddr, 32'd0);
        chk32("mid_rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        step();
        chk32("mid_rst_writes", 32'(wr_addr.size()), 32'd1);
        chk32("mid_rst_addr0", wr_addr[0], 32'd0);
        chk32("mid_rst_data0", wr_data[0], w0);
        fill_src(8, 1'b0);
        do_load(2, 0, -1, 8'd0);

        // Start pulses during LOAD are ignored; reload from RUN.
        do_reset();
        fill_src(8, 1'b0);
        do_load(2, 0, 5, 8'd1);
        fill_src(8, 1'b0);
        do_load(2, 0, 3, 8'd0);

        // Randomized chained loads from RUN.
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 8));
            gap = int'($urandom_range(0, 2));
            pa  = ($urandom_range(0, 1) == 1) ?
                  int'($urandom_range(0, 4 * len - 1)) : -1;
            if (r == 3) try_bad(int'($urandom_range(129, 255)), 1'b1);
            fill_src(4 * len, 1'b0);
            do_load(len, gap, pa, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader_ctrl.md
IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 128: instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0: byte address of the first word written.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port load_start  input  1  single-cycle request to begin a program load.
REQ-006 The block SHALL have port load_len  input  8  number of words to load, sampled with load_start.
REQ-007 The block SHALL have port byte_valid  input  1  byte_data holds a valid program byte.
REQ-008 The block SHALL have port byte_data  input  8  program byte stream, most-significant byte of each word first.
REQ-009 The block SHALL have port byte_ready  output  1  block accepts byte_data this cycle.
REQ-010 The block SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-011 The block SHALL have port mem_waddr  output  32  word-aligned byte address; bits [1:0] always 0.
REQ-012 The block SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 The block SHALL have port cpu_run  output  1  CPU may fetch and execute; 0 holds the CPU stalled.
REQ-014 The block SHALL have port load_done  output  1  one-cycle pulse when a load completes.
REQ-015 The block SHALL have port load_err  output  1  sticky error flag for an illegal load_len.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WRITE and RUN.
REQ-017 In IDLE or RUN, load_start with 1 <= load_len <= MEM_WORDS SHALL enter LOAD next cycle, clear byte and word counters, latch load_len, clear load_err, and drive cpu_run=0.
REQ-018 load_start with load_len=0 or load_len>MEM_WORDS SHALL set load_err=1 and leave state unchanged.
REQ-019 load_start SHALL be ignored in LOAD and WRITE.
REQ-020 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-021 Accepted bytes k=0..3 of a word SHALL fill mem_wdata bits [31-8k:24-8k] (big-endian).
REQ-022 Acceptance of the 4th byte SHALL move the FSM to WRITE on the next cycle.
REQ-023 WRITE SHALL last exactly one cycle, with mem_we=1, mem_waddr=BASE_ADDR+4*word_idx and mem_wdata equal to the assembled word.
REQ-024 After WRITE, word_idx SHALL increment; if the written word was word load_len-1, the FSM SHALL go to RUN, otherwise back to LOAD.
REQ-025 On entry to RUN, load_done SHALL be 1 for exactly one cycle, and cpu_run SHALL be 1 from that cycle onward while in RUN.
REQ-026 Latency from last-byte acceptance (cycle N) SHALL be: mem_we at N+1, load_done and cpu_run at N+2.
REQ-027 byte_valid gaps SHALL stall assembly without losing or duplicating bytes.
REQ-028 mem_we SHALL be 0 in every state except WRITE, and mem_waddr SHALL never exceed BASE_ADDR+4*(MEM_WORDS-1).
REQ-029 Bytes presented outside LOAD SHALL be ignored.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE with cpu_run=0, byte_ready=0, mem_we=0, load_done=0, load_err=0, mem_waddr=0, mem_wdata=0, and all counters at 0.
REQ-031 Reset mid-load SHALL discard any partial word; words already written are not rewritten, and the next load starts at BASE_ADDR.

Verification
REQ-032 Bench SHALL cover: load_len=2 with bytes 00,22,18,20,AC,01,00,00 -> mem_we writes 0x0=00221820 and 0x4=AC010000, then load_done pulse and cpu_run=1.
REQ-033 Bench SHALL cover: same load with byte_valid deasserted 3 cycles between each byte -> identical writes, with load_done delayed accordingly.
REQ-034 Bench SHALL cover: load_start with load_len=0, then with load_len=129 -> load_err=1, state stays IDLE, no mem_we.
REQ-035 Bench SHALL cover: load_len=128 with incrementing bytes -> 128 writes, last at mem_waddr=0x1FC, then RUN.
REQ-036 Bench SHALL cover: rst asserted after 6 bytes of a 4-word load -> exactly one write (addr 0), all outputs at reset values; a new load then writes from addr 0.
REQ-037 Bench SHALL cover: load_start pulsed during LOAD, and a new load issued from RUN -> the mid-LOAD pulse is ignored, and the load from RUN drops cpu_run to 0 until the new load_done.
